// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM states,
// default geometry and PC field-extract helpers.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_e;

  localparam int DEF_INDEX_BITS  = 4;
  localparam int DEF_OFFSET_BITS = 2;
  localparam int TAG_BITS        = 30 - DEF_INDEX_BITS - DEF_OFFSET_BITS;

  // Helpers return right-justified 32-bit fields; callers size-cast to the field width.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int ib, input int ob);
    return addr >> (2 + ob + ib);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int ib, input int ob);
    return (addr >> (2 + ob)) & ((32'd1 << ib) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int ob);
    return (addr >> 2) & ((32'd1 << ob) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the instruction cache: one combinational read
// port and one write port (word write, tag+valid set, valid clear).
module icache_line_store
  import icache_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic [INDEX_BITS-1:0]       rd_index,
  input  logic [OFFSET_BITS-1:0]      rd_offset,
  output logic                        rd_valid,
  output logic [29-INDEX_BITS-OFFSET_BITS:0] rd_tag,
  output logic [31:0]                 rd_data,
  input  logic                        wr_word_en,
  input  logic [INDEX_BITS-1:0]       wr_index,
  input  logic [OFFSET_BITS-1:0]      wr_offset,
  input  logic [31:0]                 wr_data,
  input  logic                        wr_tag_en,
  input  logic [29-INDEX_BITS-OFFSET_BITS:0] wr_tag,
  input  logic                        clr_en,
  input  logic [INDEX_BITS-1:0]       clr_index
);

  localparam int TAG_W = 30 - INDEX_BITS - OFFSET_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*WORDS];

  always_comb begin
    valid_d = valid_q;
    if (clr_en) begin
      valid_d[clr_index] = 1'b0;
    end
    if (wr_tag_en) begin
      valid_d[wr_index] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; a line is only trusted through its valid bit.
  always_ff @(posedge clk) begin
    if (wr_tag_en) begin
      tag_mem[wr_index] <= wr_tag;
    end
    if (wr_word_en) begin
      data_mem[{wr_index, wr_offset}] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, and on a miss a
// request/beat line fill from the memory controller before serving the hit.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        instrReqValid,
  input  logic [31:0] instrAddrIn,
  output logic        instrOutValid,
  output logic [31:0] instrOut,
  output logic [31:0] instrAddrOut,
  output logic        memReqValid,
  output logic [31:0] memReqAddr,
  input  logic        memReqReady,
  input  logic        memDataValid,
  input  logic [31:0] memDataIn
);

  localparam int TAG_W    = 30 - INDEX_BITS - OFFSET_BITS;
  localparam int LINE_LSB = 2 + OFFSET_BITS;
  localparam int LINE_W   = 32 - LINE_LSB;

  state_e                  state_q, state_d;
  logic [LINE_W-1:0]       miss_line_q, miss_line_d;
  logic [OFFSET_BITS-1:0]  cnt_q, cnt_d;

  logic [INDEX_BITS-1:0]   req_index;
  logic [OFFSET_BITS-1:0]  req_offset;
  logic [31:0]             miss_addr;
  logic [INDEX_BITS-1:0]   miss_index;
  logic [TAG_W-1:0]        miss_tag;

  logic                    rd_valid;
  logic [TAG_W-1:0]        rd_tag;
  logic [31:0]             rd_data;
  logic                    hit;
  logic                    wr_word_en;
  logic                    wr_tag_en;
  logic                    clr_en;

  assign req_index  = INDEX_BITS'(addr_index(instrAddrIn, INDEX_BITS, OFFSET_BITS));
  assign req_offset = OFFSET_BITS'(addr_offset(instrAddrIn, OFFSET_BITS));
  assign miss_addr  = {miss_line_q, {LINE_LSB{1'b0}}};
  assign miss_index = INDEX_BITS'(addr_index(miss_addr, INDEX_BITS, OFFSET_BITS));
  assign miss_tag   = TAG_W'(addr_tag(miss_addr, INDEX_BITS, OFFSET_BITS));

  icache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .OFFSET_BITS(OFFSET_BITS)
  ) u_line_store (
    .clk       (clockIn),
    .srst      (resetIn),
    .rd_index  (req_index),
    .rd_offset (req_offset),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_word_en(wr_word_en),
    .wr_index  (miss_index),
    .wr_offset (cnt_q),
    .wr_data   (memDataIn),
    .wr_tag_en (wr_tag_en),
    .wr_tag    (miss_tag),
    .clr_en    (clr_en),
    .clr_index (req_index)
  );

  assign hit          = rd_valid && (32'(rd_tag) == addr_tag(instrAddrIn, INDEX_BITS, OFFSET_BITS));
  assign instrOut     = rd_data;
  assign instrAddrOut = instrAddrIn;
  assign memReqAddr   = miss_addr;

  always_comb begin
    state_d       = state_q;
    miss_line_d   = miss_line_q;
    cnt_d         = cnt_q;
    instrOutValid = 1'b0;
    memReqValid   = 1'b0;
    wr_word_en    = 1'b0;
    wr_tag_en     = 1'b0;
    clr_en        = 1'b0;
    case (state_q)
      IDLE: begin
        instrOutValid = instrReqValid && hit;
        // The target line is invalidated up front so a partial fill can never hit.
        if (instrReqValid && !hit) begin
          miss_line_d = instrAddrIn[31:LINE_LSB];
          clr_en      = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        memReqValid = 1'b1;
        if (memReqReady) begin
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (memDataValid) begin
          wr_word_en = 1'b1;
          cnt_d      = cnt_q + OFFSET_BITS'(1);
          if (cnt_q == '1) begin
            wr_tag_en = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state_q     <= IDLE;
      miss_line_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      miss_line_q <= miss_line_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: a responding memory model, a
// table of fetches scored through an expectation queue, and corner sequences.
module tb_instruction_cache;
  import icache_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        resetIn;
  logic        instrReqValid;
  logic [31:0] instrAddrIn;
  logic        instrOutValid;
  logic [31:0] instrOut;
  logic [31:0] instrAddrOut;
  logic        memReqValid;
  logic [31:0] memReqAddr;
  logic        memReqReady;
  logic        memDataValid;
  logic [31:0] memDataIn;

  always #5 clk = ~clk;

  instruction_cache #(.INDEX_BITS(4), .OFFSET_BITS(2)) dut (
    .clockIn      (clk),
    .resetIn      (resetIn),
    .instrReqValid(instrReqValid),
    .instrAddrIn  (instrAddrIn),
    .instrOutValid(instrOutValid),
    .instrOut     (instrOut),
    .instrAddrOut (instrAddrOut),
    .memReqValid  (memReqValid),
    .memReqAddr   (memReqAddr),
    .memReqReady  (memReqReady),
    .memDataValid (memDataValid),
    .memDataIn    (memDataIn)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Backing memory contents: line 0 holds the cold-miss program, others a pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] base, input int i);
    if (base == 32'h0) begin
      case (i)
        0: return 32'h0000_0013;
        1: return 32'h0010_0093;
        2: return 32'h0020_0113;
        default: return 32'h0030_0193;
      endcase
    end
    return (base + 32'(i * 4)) ^ 32'hC0DE_0000;
  endfunction

  // Memory model: presents beats back-to-back starting the cycle after acceptance.
  bit          manual = 1'b0;
  logic        man_valid = 1'b0;
  logic [31:0] man_data = 32'h0;
  logic        mdl_valid = 1'b0;
  logic [31:0] mdl_data = 32'h0;
  bit          fill_on = 1'b0;
  int          beat_idx = 0;
  logic [31:0] fill_base = 32'h0;
  logic [31:0] req_log[$];

  assign memDataValid = manual ? man_valid : mdl_valid;
  assign memDataIn    = manual ? man_data : mdl_data;

  always @(negedge clk) begin
    if (resetIn || manual) begin
      fill_on   = 1'b0;
      mdl_valid = 1'b0;
      beat_idx  = 0;
    end else begin
      if (mdl_valid) begin
        beat_idx++;
        mdl_valid = 1'b0;
      end
      if (fill_on) begin
        if (beat_idx == N) begin
          fill_on = 1'b0;
        end else begin
          mdl_valid = 1'b1;
          mdl_data  = mem_word(fill_base, beat_idx);
        end
      end else if (memReqValid && memReqReady) begin
        fill_on   = 1'b1;
        beat_idx  = 0;
        fill_base = memReqAddr;
        req_log.push_back(memReqAddr);
      end
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    e.word = mem_word(a & 32'hFFFF_FFF0, int'(a[3:2]));
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for instrOutValid and scores it against the queued expectation.
  // exp_lat < 0 skips the latency and fill-address checks.
  task automatic wait_out(input string nm, input int exp_lat);
    int   lat = 0;
    exp_t e;
    @(negedge clk);
    while (!instrOutValid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no expectation queued", nm);
    end else begin
      e = exp_q.pop_front();
      if (!instrOutValid) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s.timeout: got no instrOutValid in %0d cycles, expected one", nm, lat);
      end else begin
        check({nm, ".data"}, instrOut, e.word);
        check({nm, ".addr"}, instrAddrOut, e.addr);
        if (exp_lat >= 0) check({nm, ".latency"}, 32'(lat), 32'(exp_lat));
        if (exp_lat > 0) begin
          if (req_log.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.memReqAddr: got no request, expected %h", nm, e.addr & 32'hFFFF_FFF0);
          end else begin
            check({nm, ".memReqAddr"}, req_log.pop_front(), e.addr & 32'hFFFF_FFF0);
          end
        end
      end
      $display("fetch %s addr=%h data=%h latency=%0d", nm, e.addr, instrOut, lat);
    end
    @(posedge clk); #1;
    instrReqValid = 1'b0;
  endtask

  task automatic fetch(input string nm, input logic [31:0] a, input int exp_lat);
    push_exp(a);
    instrAddrIn   = a;
    instrReqValid = 1'b1;
    wait_out(nm, exp_lat);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          lat;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{32'h0000_0000, 6}, '{32'h0000_0004, 0}, '{32'h0000_0008, 0}, '{32'h0000_000C, 0},
      '{32'h0000_0100, 6}, '{32'h0000_0104, 0}, '{32'h0000_0000, 6}, '{32'h0000_010C, 6},
      '{32'h0000_0044, 6}, '{32'h0000_0040, 0}, '{32'h0000_000C, 6}, '{32'h0000_004C, 0}
    };
    resetIn       = 1'b1;
    instrReqValid = 1'b0;
    instrAddrIn   = 32'h0;
    memReqReady   = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.instrOutValid", 32'(instrOutValid), 32'h0);
    check("reset.memReqValid", 32'(memReqValid), 32'h0);
    check("reset.memReqAddr", memReqAddr, 32'h0);
    instrReqValid = 1'b1;
    #1;
    check("reset.no_hit", 32'(instrOutValid), 32'h0);
    @(posedge clk); #1;
    resetIn       = 1'b0;
    instrReqValid = 1'b0;
    @(posedge clk); #1;

    // Cold miss, hits in the same line, conflict eviction and re-miss
    for (int i = 0; i < 12; i++) begin
      fetch($sformatf("vec%0d", i), tbl[i].addr, tbl[i].lat);
    end

    // Ready backpressure
    memReqReady = 1'b0;
    push_exp(32'h0000_0200);
    instrAddrIn   = 32'h0000_0200;
    instrReqValid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d.memReqValid", i), 32'(memReqValid), 32'h1);
      check($sformatf("bp%0d.memReqAddr", i), memReqAddr, 32'h0000_0200);
      check($sformatf("bp%0d.instrOutValid", i), 32'(instrOutValid), 32'h0);
      check($sformatf("bp%0d.memDataValid", i), 32'(memDataValid), 32'h0);
    end
    @(posedge clk); #1;
    memReqReady = 1'b1;
    wait_out("bp", -1);
    check("bp.req_count", 32'(req_log.size()), 32'h1);
    if (req_log.size() > 0) check("bp.req_addr", req_log.pop_front(), 32'h0000_0200);

    // Redirect mid-FILL
    instrAddrIn   = 32'h0000_1040;
    instrReqValid = 1'b1;
    for (int i = 0; i < 30 && !(fill_on && beat_idx >= 2); i++) @(negedge clk);
    check("redir.mid_fill", 32'(fill_on && beat_idx >= 2), 32'h1);
    @(posedge clk); #1;
    instrAddrIn = 32'h0000_1080;
    push_exp(32'h0000_1080);
    wait_out("redir", -1);
    check("redir.req_count", 32'(req_log.size()), 32'h2);
    if (req_log.size() == 2) begin
      check("redir.req0", req_log[0], 32'h0000_1040);
      check("redir.req1", req_log[1], 32'h0000_1080);
    end
    req_log.delete();
    fetch("redir_old_line", 32'h0000_1040, 0);

    // instrReqValid low on a missing address never starts a fill
    instrReqValid = 1'b0;
    instrAddrIn   = 32'h0000_3000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("noreq%0d.memReqValid", i), 32'(memReqValid), 32'h0);
    end
    @(posedge clk); #1;
    fetch("noreq_then_req", 32'h0000_3000, 6);

    // Reset after two beats of line 0x2020, then stray beats in IDLE
    manual        = 1'b1;
    man_valid     = 1'b0;
    instrAddrIn   = 32'h0000_2020;
    instrReqValid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    man_valid = 1'b1;
    man_data  = mem_word(32'h0000_2020, 0);
    @(posedge clk); #1;
    man_data = mem_word(32'h0000_2020, 1);
    @(posedge clk); #1;
    resetIn  = 1'b1;
    man_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    resetIn       = 1'b0;
    instrReqValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    man_valid = 1'b0;
    manual    = 1'b0;
    fetch("rst_fill_remiss", 32'h0000_2020, 6);
    fetch("rst_fill_line0", 32'h0000_0000, 6);
    manual    = 1'b1;
    man_valid = 1'b1;
    man_data  = 32'hBAD0_BAD0;
    repeat (3) @(posedge clk);
    #1;
    man_valid = 1'b0;
    manual    = 1'b0;
    fetch("stray_line0", 32'h0000_0004, 0);
    fetch("stray_line2020", 32'h0000_2028, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
